// File: rtl/filtro_entradas_porta.sv
// Door-controller input conditioner: 2-flop synchronizer plus per-channel
// counter debounce, with registered rising-edge and any-change strobes.

module filtro_entradas_porta_canal #(
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int CNT_W           = 8
) (
   input  logic clock,
   input  logic reset_n,
   input  logic i_raw,
   output logic o_stable,
   output logic o_accept
);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             r_sync1, r_sync2, r_stable;
   logic [CNT_W-1:0] r_cnt;
   logic             w_differs;

   assign w_differs = (r_sync2 != r_stable);
   // Acceptance is decided combinationally so the top can register its strobes
   // on the very edge that updates r_stable.
   assign o_accept  = w_differs && (r_cnt == LAST);
   assign o_stable  = r_stable;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_sync1  <= 1'b0;
         r_sync2  <= 1'b0;
         r_stable <= 1'b0;
         r_cnt    <= '0;
      end else begin
         r_sync1 <= i_raw;
         r_sync2 <= r_sync1;
         if (!w_differs) begin
            r_cnt <= '0;
         end else if (o_accept) begin
            r_stable <= r_sync2;
            r_cnt    <= '0;
         end else begin
            r_cnt <= r_cnt + CNT_W'(1);
         end
      end
   end
endmodule

module filtro_entradas_porta #(
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int CNT_W           = 8
) (
   input  logic       clock,
   input  logic       reset_n,
   input  logic [3:0] sensor_in,
   output logic [3:0] sensor_out,
   output logic [3:0] pulso_subida,
   output logic       mudou
);
   localparam int NUM_CH = 4;

   logic [NUM_CH-1:0] w_stable, w_accept;
   logic [NUM_CH-1:0] r_pulso;
   logic              r_mudou;

   for (genvar i = 0; i < NUM_CH; i++) begin : g_canal
      filtro_entradas_porta_canal #(
         .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
         .CNT_W          (CNT_W)
      ) u_canal (
         .clock   (clock),
         .reset_n (reset_n),
         .i_raw   (sensor_in[i]),
         .o_stable(w_stable[i]),
         .o_accept(w_accept[i])
      );
   end

   // An accepted change on a channel currently at 0 is necessarily a rise.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_pulso <= '0;
         r_mudou <= 1'b0;
      end else begin
         r_pulso <= w_accept & ~w_stable;
         r_mudou <= |w_accept;
      end
   end

   assign sensor_out   = w_stable;
   assign pulso_subida = r_pulso;
   assign mudou        = r_mudou;
endmodule

// File: tb/tb_filtro_entradas_porta.sv
// Directed bench for filtro_entradas_porta at DEBOUNCE_CYCLES=4, 50-unit clock.

module tb_filtro_entradas_porta;
   logic       clock = 1'b0;
   logic       reset_n;
   logic [3:0] sensor_in;
   logic [3:0] sensor_out, pulso_subida;
   logic       mudou;
   int         errors = 0;
   int         checks = 0;

   filtro_entradas_porta #(.DEBOUNCE_CYCLES(4), .CNT_W(8)) dut (
      .clock       (clock),
      .reset_n     (reset_n),
      .sensor_in   (sensor_in),
      .sensor_out  (sensor_out),
      .pulso_subida(pulso_subida),
      .mudou       (mudou)
   );

   always #25 clock = ~clock;

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   // Step n edges expecting quiet outputs at level exp_out.
   task automatic quiet(input int n, input logic [3:0] exp_out, input string name);
      for (int k = 1; k <= n; k++) begin
         tick();
         checks++;
         if (sensor_out !== exp_out || pulso_subida !== 4'b0000 || mudou !== 1'b0) begin
            errors++;
            $display("FAIL %s edge %0d: out=%b pulso=%b mudou=%b, want out=%b pulso=0000 mudou=0",
                     name, k, sensor_out, pulso_subida, mudou, exp_out);
         end
      end
   endtask

   task automatic test_reset();
      reset_n = 1'b0; sensor_in = 4'b0000;
      #1;
      checks++;
      if (sensor_out !== 4'b0000 || pulso_subida !== 4'b0000 || mudou !== 1'b0) begin
         errors++;
         $display("FAIL reset_initial: out=%b pulso=%b mudou=%b, want 0000/0000/0", sensor_out, pulso_subida, mudou);
      end
      tick(); tick();
      #10 reset_n = 1'b1;
      tick();
      sensor_in = 4'b1111;
      quiet(5, 4'b0000, "reset_fill");
      tick();
      checks++;
      if (sensor_out !== 4'b1111 || pulso_subida !== 4'b1111 || mudou !== 1'b1) begin
         errors++;
         $display("FAIL reset_fill_accept: out=%b pulso=%b mudou=%b, want 1111/1111/1", sensor_out, pulso_subida, mudou);
      end
      // Mid-cycle assertion must clear outputs before the next edge.
      #10 reset_n = 1'b0;
      #1;
      checks++;
      if (sensor_out !== 4'b0000 || pulso_subida !== 4'b0000 || mudou !== 1'b0) begin
         errors++;
         $display("FAIL reset_async: out=%b pulso=%b mudou=%b, want 0000/0000/0", sensor_out, pulso_subida, mudou);
      end
      quiet(3, 4'b0000, "reset_held");
      sensor_in = 4'b0000;
      #10 reset_n = 1'b1;
      quiet(4, 4'b0000, "reset_release");
   endtask

   task automatic test_clean_step();
      sensor_in = 4'b1100;
      quiet(5, 4'b0000, "step_wait");
      tick();
      checks++;
      if (sensor_out !== 4'b1100 || pulso_subida !== 4'b1100 || mudou !== 1'b1) begin
         errors++;
         $display("FAIL step_accept: out=%b pulso=%b mudou=%b, want 1100/1100/1", sensor_out, pulso_subida, mudou);
      end
      quiet(2, 4'b1100, "step_after");
   endtask

   task automatic test_glitch();
      for (int len = 2; len <= 3; len++) begin
         sensor_in = 4'b1101;
         for (int k = 0; k < len; k++) tick();
         sensor_in = 4'b1100;
         quiet(8, 4'b1100, $sformatf("glitch_%0d", len));
      end
   endtask

   task automatic test_falling();
      sensor_in = 4'b1101;
      quiet(5, 4'b1100, "fall_setup_wait");
      tick();
      checks++;
      if (sensor_out !== 4'b1101 || pulso_subida !== 4'b0001 || mudou !== 1'b1) begin
         errors++;
         $display("FAIL fall_setup: out=%b pulso=%b mudou=%b, want 1101/0001/1", sensor_out, pulso_subida, mudou);
      end
      sensor_in = 4'b0110;
      quiet(5, 4'b1101, "fall_wait");
      tick();
      checks++;
      if (sensor_out !== 4'b0110 || pulso_subida !== 4'b0010 || mudou !== 1'b1) begin
         errors++;
         $display("FAIL fall_accept: out=%b pulso=%b mudou=%b, want 0110/0010/1", sensor_out, pulso_subida, mudou);
      end
      quiet(2, 4'b0110, "fall_after");
   endtask

   task automatic test_bounce();
      int rises = 0;
      for (int k = 0; k < 10; k++) begin
         sensor_in = {~k[0], 3'b110};
         tick();
         if (mudou === 1'b1) rises++;
      end
      sensor_in = 4'b1110;
      for (int k = 1; k <= 8; k++) begin
         tick();
         if (mudou === 1'b1) rises++;
         if (k == 5 || k == 6) begin
            checks++;
            if (sensor_out !== (k == 6 ? 4'b1110 : 4'b0110) || pulso_subida !== (k == 6 ? 4'b1000 : 4'b0000)) begin
               errors++;
               $display("FAIL bounce_edge%0d: out=%b pulso=%b, want out=%b pulso=%b", k, sensor_out, pulso_subida,
                        (k == 6 ? 4'b1110 : 4'b0110), (k == 6 ? 4'b1000 : 4'b0000));
            end
         end
      end
      checks++;
      if (rises !== 1) begin
         errors++;
         $display("FAIL bounce_count: strobes=%0d, want 1", rises);
      end
   endtask

   // Rise then fall on bit0 at the minimum spacing of DEBOUNCE_CYCLES edges.
   task automatic test_back_to_back();
      sensor_in = 4'b1111;
      quiet(4, 4'b1110, "b2b_rise_wait");
      sensor_in = 4'b1110;
      quiet(1, 4'b1110, "b2b_rise_wait5");
      tick();
      checks++;
      if (sensor_out !== 4'b1111 || pulso_subida !== 4'b0001 || mudou !== 1'b1) begin
         errors++;
         $display("FAIL b2b_rise: out=%b pulso=%b mudou=%b, want 1111/0001/1", sensor_out, pulso_subida, mudou);
      end
      quiet(3, 4'b1111, "b2b_hold");
      tick();
      checks++;
      if (sensor_out !== 4'b1110 || pulso_subida !== 4'b0000 || mudou !== 1'b1) begin
         errors++;
         $display("FAIL b2b_fall: out=%b pulso=%b mudou=%b, want 1110/0000/1", sensor_out, pulso_subida, mudou);
      end
      quiet(2, 4'b1110, "b2b_after");
   endtask

   task automatic test_reset_mid_count();
      sensor_in = 4'b1010;
      quiet(3, 4'b1110, "midrst_pre");
      #10 reset_n = 1'b0;
      #1;
      checks++;
      if (sensor_out !== 4'b0000 || pulso_subida !== 4'b0000 || mudou !== 1'b0) begin
         errors++;
         $display("FAIL midrst_clear: out=%b pulso=%b mudou=%b, want 0000/0000/0", sensor_out, pulso_subida, mudou);
      end
      quiet(1, 4'b0000, "midrst_held");
      #10 reset_n = 1'b1;
      quiet(5, 4'b0000, "midrst_wait");
      tick();
      checks++;
      if (sensor_out !== 4'b1010 || pulso_subida !== 4'b1010 || mudou !== 1'b1) begin
         errors++;
         $display("FAIL midrst_accept: out=%b pulso=%b mudou=%b, want 1010/1010/1", sensor_out, pulso_subida, mudou);
      end
      quiet(2, 4'b1010, "midrst_after");
   endtask

   initial begin
      test_reset();
      test_clean_step();
      test_glitch();
      test_falling();
      test_bounce();
      test_back_to_back();
      test_reset_mid_count();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
